// File: rtl/audio_pkg.sv
// Shared audio definitions for the codec receive and transmit paths.
package audio_pkg;

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned SAMPLE_W = 16;

  // Bit sampled two clk after the bit-clock rising edge.
  localparam logic [2:0]       CAPTURE_PHASE = 3'b110;
  // Last capture cycle of a stereo frame (final right-channel bit).
  localparam logic [CNT_W-1:0] FRAME_END     = 8'hFE;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } audio_state_e;

endpackage

// File: rtl/mic_control_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous codec data into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the raw input through two stages.
  always_comb begin
    sync_d = {sync_q[0], d};
  end

  // Synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign q = sync_q[1];

endmodule

// File: rtl/mic_control.sv
// Codec master-mode receiver: generates bit/word clocks from a frame counter,
// deserialises MSB-first left/right samples and hands out stereo pairs with a
// valid/ack handshake and sticky overrun flag.
module mic_control
  import audio_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                audio_appsel,
  output logic                audio_sysclk,
  output logic                audio_bck,
  output logic                audio_ws,
  input  logic                audio_data,
  output logic [SAMPLE_W-1:0] audio_left,
  output logic [SAMPLE_W-1:0] audio_right,
  output logic                sample_valid,
  input  logic                sample_ack,
  output logic                overrun,
  input  logic                overrun_clr
);

  audio_state_e        state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] left_sh_q, left_sh_d;
  logic [SAMPLE_W-1:0] right_sh_q, right_sh_d;
  logic [SAMPLE_W-1:0] left_q, left_d;
  logic [SAMPLE_W-1:0] right_q, right_d;
  logic                done_q, done_d;
  logic                discard_q, discard_d;
  logic                valid_q, valid_d;
  logic                ovr_q, ovr_d;
  logic                data_sync;
  logic                capture;
  logic                update;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (audio_data),
    .q     (data_sync)
  );

  // State follows en; the counter advances on every clk that ends in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = RUN;
      RUN:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d = (state_d == RUN) ? cnt_q + CNT_W'(1) : '0;
  end

  assign capture = (state_q == RUN) && en && (cnt_q[2:0] == CAPTURE_PHASE);
  assign update  = done_q && en && !discard_q;

  // Deserialise into the channel selected by the word clock; flag frame end.
  always_comb begin
    left_sh_d  = left_sh_q;
    right_sh_d = right_sh_q;
    done_d     = 1'b0;
    if (capture) begin
      if (!cnt_q[CNT_W-1]) left_sh_d  = {left_sh_q[SAMPLE_W-2:0], data_sync};
      else                 right_sh_d = {right_sh_q[SAMPLE_W-2:0], data_sync};
      done_d = (cnt_q == FRAME_END);
    end
  end

  // Output pair, handshake and overrun; an update beats a same-cycle ack.
  always_comb begin
    left_d    = update ? left_sh_q  : left_q;
    right_d   = update ? right_sh_q : right_q;
    discard_d = discard_q;
    if (!en)         discard_d = 1'b1;
    else if (done_q) discard_d = 1'b0;
    valid_d = valid_q;
    if (sample_ack) valid_d = 1'b0;
    if (update)     valid_d = 1'b1;
    if (!en)        valid_d = 1'b0;
    ovr_d = ovr_q;
    if (overrun_clr)                       ovr_d = 1'b0;
    if (update && valid_q && !sample_ack) ovr_d = 1'b1;
  end

  // All state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      left_sh_q  <= '0;
      right_sh_q <= '0;
      left_q     <= '0;
      right_q    <= '0;
      done_q     <= 1'b0;
      discard_q  <= 1'b1;
      valid_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      left_sh_q  <= left_sh_d;
      right_sh_q <= right_sh_d;
      left_q     <= left_d;
      right_q    <= right_d;
      done_q     <= done_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      ovr_q      <= ovr_d;
    end
  end

  assign audio_appsel = 1'b1;
  assign audio_sysclk = clk;
  assign audio_bck    = cnt_q[2];
  assign audio_ws     = cnt_q[CNT_W-1];
  assign audio_left   = left_q;
  assign audio_right  = right_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_mic_control.sv
// Bench for mic_control: a codec model serialises chosen words off the DUT's
// bit/word clocks; expectations come from the words the codec actually sent.
module tb_mic_control;

  logic        clk = 1'b0;
  logic        rst_n, en, sample_ack, overrun_clr;
  logic        audio_appsel, audio_sysclk, audio_bck, audio_ws;
  logic        audio_data = 1'b0;
  logic [15:0] audio_left, audio_right;
  logic        sample_valid, overrun;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned ecnt = 0;
  int unsigned base = 0;

  // Codec model state (owned by the codec process, except next_* and resync_cnt).
  logic [15:0] next_l = '0, next_r = '0, cur_l = '0, cur_r = '0;
  int unsigned resync_cnt = 0, resync_seen = 0, idx = 0;
  logic        last_ws = 1'b0;
  logic [31:0] sent[$];
  event        resync_ev;

  mic_control dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .audio_appsel (audio_appsel),
    .audio_sysclk (audio_sysclk),
    .audio_bck    (audio_bck),
    .audio_ws     (audio_ws),
    .audio_data   (audio_data),
    .audio_left   (audio_left),
    .audio_right  (audio_right),
    .sample_valid (sample_valid),
    .sample_ack   (sample_ack),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  // Codec: changes data after each bck fall, MSB first, new word on each ws edge;
  // records every stereo frame it starts transmitting.
  always begin
    @(negedge audio_bck or resync_ev);
    #1;
    if (resync_seen != resync_cnt) begin
      resync_seen = resync_cnt;
      sent.delete();
      idx     = 0;
      last_ws = 1'b0;
      cur_l   = next_l;
      cur_r   = next_r;
      sent.push_back({cur_l, cur_r});
    end else if (audio_ws != last_ws) begin
      last_ws = audio_ws;
      idx     = 0;
      if (!audio_ws) begin
        cur_l = next_l;
        cur_r = next_r;
        sent.push_back({cur_l, cur_r});
      end
    end else if (idx < 15) begin
      idx++;
    end
    audio_data = last_ws ? cur_r[4'(15 - idx)] : cur_l[4'(15 - idx)];
  end

  task automatic wait_until(input int unsigned n);
    while (ecnt - base < n) @(negedge clk);
  endtask

  task automatic start_capture(input logic [15:0] l, input logic [15:0] r);
    @(negedge clk);
    en = 1'b0; sample_ack = 1'b0; overrun_clr = 1'b1;
    next_l = l; next_r = r;
    @(negedge clk);
    overrun_clr = 1'b0;
    resync_cnt++;
    ->resync_ev;
    en = 1'b1;
    base = ecnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; sample_ack = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({audio_bck, audio_ws, sample_valid, overrun} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000", {audio_bck, audio_ws, sample_valid, overrun});
    end
    checks++;
    if ({audio_left, audio_right} !== 32'h0) begin
      errors++; $display("FAIL reset_samples: got %h expected 0", {audio_left, audio_right});
    end
    checks++;
    if (audio_appsel !== 1'b1) begin
      errors++; $display("FAIL reset_appsel: got %b expected 1", audio_appsel);
    end
    checks++;
    if (audio_sysclk !== clk) begin
      errors++; $display("FAIL sysclk_low: got %b expected %b", audio_sysclk, clk);
    end
    @(posedge clk); #1;
    checks++;
    if (audio_sysclk !== clk) begin
      errors++; $display("FAIL sysclk_high: got %b expected %b", audio_sysclk, clk);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if ({audio_bck, audio_ws, sample_valid} !== 3'b0) begin
      errors++; $display("FAIL idle_quiet: got %b expected 000", {audio_bck, audio_ws, sample_valid});
    end
  endtask

  task automatic test_first_frames();
    start_capture(16'hA5C3, 16'h7F01);
    wait_until(256);
    checks++;
    if (sample_valid !== 1'b0 || {audio_left, audio_right} !== 32'h0) begin
      errors++; $display("FAIL first_discard: got v=%b %h expected v=0 0", sample_valid, {audio_left, audio_right});
    end
    wait_until(511);
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL pre_valid: got %b expected 0", sample_valid);
    end
    wait_until(512);
    checks++;
    if (sample_valid !== 1'b1 || audio_left !== 16'hA5C3 || audio_right !== 16'h7F01) begin
      errors++; $display("FAIL second_frame: got v=%b L=%h R=%h expected v=1 L=a5c3 R=7f01",
                         sample_valid, audio_left, audio_right);
    end
  endtask

  task automatic test_overrun();
    start_capture(16'h0001, 16'h1234);
    wait_until(300); next_l = 16'h8000;
    wait_until(512);
    checks++;
    if (audio_left !== 16'h0001 || sample_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first: got L=%h v=%b o=%b expected L=0001 v=1 o=0", audio_left, sample_valid, overrun);
    end
    wait_until(767);
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_early: got %b expected 0", overrun);
    end
    wait_until(768);
    checks++;
    if (overrun !== 1'b1 || audio_left !== 16'h8000 || sample_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_set: got o=%b L=%h v=%b expected o=1 L=8000 v=1", overrun, audio_left, sample_valid);
    end
    overrun_clr = 1'b1;
    wait_until(769); overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b0 || sample_valid !== 1'b1) begin
      errors++; $display("FAIL ovr_clr: got o=%b v=%b expected o=0 v=1", overrun, sample_valid);
    end
    wait_until(1023); overrun_clr = 1'b1;
    wait_until(1024); overrun_clr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL ovr_clr_collide: got %b expected 1", overrun);
    end
  endtask

  task automatic test_ack_on_update();
    start_capture(16'h1357, 16'h2468);
    wait_until(767); sample_ack = 1'b1;
    wait_until(768); sample_ack = 1'b0;
    checks++;
    if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL ack_on_update: got v=%b o=%b expected v=1 o=0", sample_valid, overrun);
    end
    wait_until(800); sample_ack = 1'b1;
    wait_until(801); sample_ack = 1'b0;
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++; $display("FAIL ack_clears: got %b expected 0", sample_valid);
    end
    wait_until(850); sample_ack = 1'b1;
    wait_until(851); sample_ack = 1'b0;
    wait_until(1024);
    checks++;
    if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
      errors++; $display("FAIL ack_ignored: got v=%b o=%b expected v=1 o=0", sample_valid, overrun);
    end
  endtask

  task automatic test_en_drop();
    start_capture(16'hC0DE, 16'hBEEF);
    wait_until(512 + 'h90);
    en = 1'b0; next_l = 16'h1111; next_r = 16'h2222;
    repeat (20) @(negedge clk);
    checks++;
    if (sample_valid !== 1'b0 || audio_left !== 16'hC0DE || audio_right !== 16'hBEEF) begin
      errors++; $display("FAIL idle_hold: got v=%b L=%h R=%h expected v=0 L=c0de R=beef", sample_valid, audio_left, audio_right);
    end
    checks++;
    if ({audio_bck, audio_ws} !== 2'b0) begin
      errors++; $display("FAIL idle_clocks: got %b expected 00", {audio_bck, audio_ws});
    end
    resync_cnt++;
    ->resync_ev;
    en = 1'b1;
    base = ecnt;
    wait_until(255); next_l = 16'h3333; next_r = 16'h4444;
    wait_until(256);
    checks++;
    if (sample_valid !== 1'b0 || audio_left !== 16'hC0DE) begin
      errors++; $display("FAIL reen_discard: got v=%b L=%h expected v=0 L=c0de", sample_valid, audio_left);
    end
    wait_until(512);
    checks++;
    if (sample_valid !== 1'b1 || audio_left !== 16'h3333 || audio_right !== 16'h4444) begin
      errors++; $display("FAIL reen_valid: got v=%b L=%h R=%h expected v=1 L=3333 R=4444", sample_valid, audio_left, audio_right);
    end
  endtask

  task automatic test_reset_mid_frame();
    start_capture(16'h5A5A, 16'h0FF0);
    wait_until(512 + 'h57);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({audio_bck, audio_ws, sample_valid, overrun, audio_left, audio_right} !== 36'h0) begin
      errors++; $display("FAIL async_reset: got %h expected 0",
                         {audio_bck, audio_ws, sample_valid, overrun, audio_left, audio_right});
    end
    @(negedge clk);
    rst_n = 1'b1;
    resync_cnt++;
    ->resync_ev;
    base = ecnt;
    for (int unsigned k = 1; k <= 4; k++) begin
      wait_until(k);
      checks++;
      if (audio_bck !== (k == 4)) begin
        errors++; $display("FAIL bck_rise_clk%0d: got %b expected %b", k, audio_bck, (k == 4));
      end
    end
    wait_until(512);
    checks++;
    if (sample_valid !== 1'b1 || audio_left !== 16'h5A5A || audio_right !== 16'h0FF0) begin
      errors++; $display("FAIL post_reset_frame: got v=%b L=%h R=%h expected v=1 L=5a5a R=0ff0", sample_valid, audio_left, audio_right);
    end
  endtask

  task automatic test_random();
    logic        valid_m, ovr_m;
    logic [31:0] pair;
    start_capture(16'($urandom), 16'($urandom));
    valid_m = 1'b0;
    ovr_m   = 1'b0;
    for (int unsigned f = 1; f <= 7; f++) begin
      wait_until(256 * (f - 1) + 100);
      next_l = 16'($urandom);
      next_r = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        wait_until(256 * (f - 1) + 150); sample_ack = 1'b1;
        wait_until(256 * (f - 1) + 151); sample_ack = 1'b0;
        valid_m = 1'b0;
        checks++;
        if (sample_valid !== valid_m) begin
          errors++; $display("FAIL rnd_ack f%0d: got %b expected %b", f, sample_valid, valid_m);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        wait_until(256 * (f - 1) + 180); overrun_clr = 1'b1;
        wait_until(256 * (f - 1) + 181); overrun_clr = 1'b0;
        ovr_m = 1'b0;
      end
      wait_until(256 * f);
      if (f >= 2) begin
        ovr_m   = ovr_m | valid_m;
        valid_m = 1'b1;
        pair = (sent.size() >= f) ? sent[f - 1] : 32'hxxxx_xxxx;
        checks++;
        if ({audio_left, audio_right} !== pair) begin
          errors++; $display("FAIL rnd_pair f%0d: got %h expected %h", f, {audio_left, audio_right}, pair);
        end
      end
      checks++;
      if (sample_valid !== valid_m || overrun !== ovr_m) begin
        errors++; $display("FAIL rnd_flags f%0d: got v=%b o=%b expected v=%b o=%b", f, sample_valid, overrun, valid_m, ovr_m);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; sample_ack = 1'b0; overrun_clr = 1'b0;
    test_reset();
    test_first_frames();
    test_overrun();
    test_ack_on_update();
    test_en_drop();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_control.md
MIC_CONTROL -- requirements
Module: mic_control

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, also forwarded as codec master clock.
REQ-002 SHALL have ports: rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports: en  in  1  capture enable; 0 forces IDLE.
REQ-004 SHALL have ports: audio_appsel  out  1  codec mode select, constant 1.
REQ-005 SHALL have ports: audio_sysclk  out  1  equals clk combinationally.
REQ-006 SHALL have ports: audio_bck  out  1  bit clock, codec serial-data reference.
REQ-007 SHALL have ports: audio_ws  out  1  word select; 0 = left, 1 = right.
REQ-008 SHALL have ports: audio_data  in  1  serial ADC data, asynchronous to clk.
REQ-009 SHALL have ports: audio_left  out  16  last complete left sample, two's complement.
REQ-010 SHALL have ports: audio_right  out  16  last complete right sample, two's complement.
REQ-011 SHALL have ports: sample_valid  out  1  new stereo pair available; held until acknowledged.
REQ-012 SHALL have ports: sample_ack  in  1  consumer acknowledge, sampled on clk.
REQ-013 SHALL have ports: overrun  out  1  sticky: a pair was overwritten before ack.
REQ-014 SHALL have ports: overrun_clr  in  1  clears overrun.

Function
REQ-015 SHALL run an 8-bit free-running clk_cnt, incrementing every clk in RUN, held at 0 in IDLE; wraps 255->0.
REQ-016 SHALL drive audio_bck = clk_cnt[2] and audio_ws = clk_cnt[7] as registered-counter decodes: 8 clk per bit, 16 bits per channel, 256 clk per frame.
REQ-017 SHALL pass audio_data through a 2-flop synchronizer before use.
REQ-018 SHALL capture the synchronized bit when clk_cnt[2:0] == 3'b110 (two clk after bck rise).
REQ-019 SHALL treat clk_cnt[6:3] as bit index, index 0 = MSB, MSB-first, no one-bit I2S delay.
REQ-020 SHALL shift left-channel bits into a 16-bit left shift register while clk_cnt[7]=0 and right-channel bits into a right shift register while clk_cnt[7]=1.
REQ-021 SHALL declare a frame complete on the capture cycle with clk_cnt == 8'hFE; next clk, audio_left/audio_right update together from the shift registers (right includes the bit captured at 8'hFE).
REQ-022 SHALL implement states IDLE and RUN: IDLE->RUN when en=1; RUN->IDLE when en=0, taking effect the next clk, mid-frame partial data discarded.
REQ-023 SHALL discard the first complete frame after each IDLE->RUN transition (no output update, no valid).
REQ-024 SHALL set sample_valid on each non-discarded output update; clear it on the clk after sample_ack=1; sample_ack with sample_valid=0 is ignored.
REQ-025 SHALL set overrun when an output update occurs while sample_valid=1 and sample_ack=0 that clk; outputs are still overwritten, sample_valid stays 1.
REQ-026 SHALL, on simultaneous sample_ack and output update, keep sample_valid=1 and not set overrun.
REQ-027 SHALL clear overrun on overrun_clr=1; if overrun_clr coincides with a new overrun event, overrun ends at 1.
REQ-028 SHALL hold audio_left/audio_right, overrun in IDLE; SHALL clear sample_valid on entering IDLE.

Reset
REQ-029 SHALL on rst_n=0 force: state IDLE, clk_cnt=0, audio_bck=0, audio_ws=0, shift registers=0, synchronizer=0, audio_left=0, audio_right=0, sample_valid=0, overrun=0, discard flag set.
REQ-030 SHALL keep audio_appsel=1 and audio_sysclk=clk during reset.

Structure
REQ-031 SHALL place CNT_W=8, SAMPLE_W=16, CAPTURE_PHASE=3'b110, FRAME_END=8'hFE and the state encoding in a shared audio package used with the transmitter.
REQ-032 SHALL instantiate one sub-module, sync_2ff, for the audio_data synchronizer.

Verification
REQ-033 Reset mid-frame (clk_cnt=8'h57): all outputs zero within 0 clk; after release with en=1, bck first rises at clk 4.
REQ-034 Codec model driving L=16'hA5C3, R=16'h7F01 every frame, en=1: first frame produces no valid; second gives audio_left=A5C3, audio_right=7F01, sample_valid rising one clk after clk_cnt=FE.
REQ-035 No ack across two updates (L=0001 then L=8000): overrun=1, audio_left=8000, sample_valid=1; overrun_clr -> overrun=0 next clk.
REQ-036 sample_ack asserted exactly on the update cycle: sample_valid stays 1, overrun stays 0.
REQ-037 en dropped at clk_cnt=8'h90 then reasserted: no update from the broken frame, first new frame discarded, third frame valid.
